// File: rtl/dir_queue_if.sv
// Game-side control strobes, raw key inputs and per-player direction/queue status.
`timescale 1ns/1ps
interface dir_queue_if #(
  parameter int N_PLAYERS   = 2,
  parameter int QUEUE_DEPTH = 4
);
  localparam int CW = $clog2(QUEUE_DEPTH + 1);

  logic                    stage;
  logic                    tick;
  logic [4*N_PLAYERS-1:0]  keys_n;
  logic [4*N_PLAYERS-1:0]  dir;
  logic [N_PLAYERS-1:0]    dir_valid;
  logic [N_PLAYERS*CW-1:0] q_count;
  logic [N_PLAYERS-1:0]    overflow;

  modport master (output stage, tick, keys_n,
                  input  dir, dir_valid, q_count, overflow);
  modport slave  (input  stage, tick, keys_n,
                  output dir, dir_valid, q_count, overflow);
endinterface

// File: rtl/dir_queue_controller.sv
// Per-player key synchronizer/debouncer feeding a small turn queue that is popped on
// each game tick; turns that repeat or reverse the last queued direction are rejected.
`timescale 1ns/1ps
module dir_queue_controller #(
  parameter int N_PLAYERS       = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int QUEUE_DEPTH     = 4
) (
  input  logic        clk,
  input  logic        reset,
  dir_queue_if.slave  bus
);
  localparam int CW = $clog2(QUEUE_DEPTH + 1);
  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0] CNT_LAST = DW'(DEBOUNCE_CYCLES - 1);

  function automatic logic is_horiz(input logic [3:0] d);
    return d[2] | d[3];
  endfunction

  for (genvar p = 0; p < N_PLAYERS; p++) begin : g_player
    logic [3:0]          sync1_q, sync2_q, deb_q, deb_d, press_q, press_d;
    logic [3:0][DW-1:0]  dcnt_q, dcnt_d;
    logic [3:0]          mem_q [QUEUE_DEPTH];
    logic [PW-1:0]       rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0]       count_q, count_d;
    logic [3:0]          dir_q, dir_d, cand_s, ref_s;
    logic                dir_valid_q, dir_valid_d, ovf_q, ovf_d;
    logic                ref_valid_s, legal_s, pop_s, push_s;

    // Debounce: flip only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    // Press pulses are suppressed while the stage is down so a held key cannot fire on rise.
    always_comb begin
      deb_d   = deb_q;
      dcnt_d  = dcnt_q;
      press_d = 4'b0000;
      for (int k = 0; k < 4; k++) begin
        if (sync2_q[k] != deb_q[k]) begin
          if (dcnt_q[k] == CNT_LAST) begin
            deb_d[k]   = sync2_q[k];
            dcnt_d[k]  = '0;
            press_d[k] = ~sync2_q[k] & bus.stage;
          end else begin
            dcnt_d[k]  = dcnt_q[k] + DW'(1);
          end
        end else begin
          dcnt_d[k] = '0;
        end
      end
    end

    // Synchronizer, debounce state and press pulse registers.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        sync1_q <= 4'hF;
        sync2_q <= 4'hF;
        deb_q   <= 4'hF;
        dcnt_q  <= '0;
        press_q <= 4'h0;
      end else begin
        sync1_q <= bus.keys_n[4*p +: 4];
        sync2_q <= sync1_q;
        deb_q   <= deb_d;
        dcnt_q  <= dcnt_d;
        press_q <= press_d;
      end
    end

    // Turn arbitration, legality against the tail (or current direction) and queue bookkeeping.
    always_comb begin
      if (press_q[0])      cand_s = 4'b0001;
      else if (press_q[1]) cand_s = 4'b0010;
      else if (press_q[2]) cand_s = 4'b0100;
      else if (press_q[3]) cand_s = 4'b1000;
      else                 cand_s = 4'b0000;

      if (count_q != '0) begin
        ref_s       = mem_q[wr_q - PW'(1)];
        ref_valid_s = 1'b1;
      end else begin
        ref_s       = dir_q;
        ref_valid_s = dir_valid_q;
      end

      legal_s = (cand_s != 4'b0000) &&
                (!ref_valid_s || (is_horiz(cand_s) != is_horiz(ref_s)));
      pop_s   = bus.stage && bus.tick && (count_q != '0);
      push_s  = bus.stage && legal_s && ((count_q != CW'(QUEUE_DEPTH)) || pop_s);

      rd_d        = rd_q;
      wr_d        = wr_q;
      count_d     = count_q;
      dir_d       = dir_q;
      dir_valid_d = dir_valid_q;
      ovf_d       = ovf_q;
      if (!bus.stage) begin
        rd_d    = '0;
        wr_d    = '0;
        count_d = '0;
        ovf_d   = 1'b0;
      end else begin
        if (pop_s) begin
          dir_d       = mem_q[rd_q];
          dir_valid_d = 1'b1;
          rd_d        = rd_q + PW'(1);
        end else begin
          rd_d        = rd_q;
        end
        if (push_s) begin
          wr_d = wr_q + PW'(1);
        end else begin
          wr_d = wr_q;
        end
        if (legal_s && !push_s) begin
          ovf_d = 1'b1;
        end else begin
          ovf_d = ovf_q;
        end
        case ({push_s, pop_s})
          2'b10:   count_d = count_q + CW'(1);
          2'b01:   count_d = count_q - CW'(1);
          default: count_d = count_q;
        endcase
      end
    end

    // Queue storage, pointers and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int i = 0; i < QUEUE_DEPTH; i++) mem_q[i] <= 4'h0;
        rd_q        <= '0;
        wr_q        <= '0;
        count_q     <= '0;
        dir_q       <= 4'h0;
        dir_valid_q <= 1'b0;
        ovf_q       <= 1'b0;
      end else begin
        if (push_s) mem_q[wr_q] <= cand_s;
        rd_q        <= rd_d;
        wr_q        <= wr_d;
        count_q     <= count_d;
        dir_q       <= dir_d;
        dir_valid_q <= dir_valid_d;
        ovf_q       <= ovf_d;
      end
    end

    assign bus.dir[4*p +: 4]        = dir_q;
    assign bus.dir_valid[p]         = dir_valid_q;
    assign bus.q_count[CW*p +: CW]  = count_q;
    assign bus.overflow[p]          = ovf_q;
  end

endmodule

// File: tb/tb_dir_queue_controller.sv
// Directed scenarios plus randomized key/tick/stage/reset traffic, checked every cycle
// against a list-based behavioural model of the direction queues.
`timescale 1ns/1ps
module tb_dir_queue_controller;
  localparam int NP = 2;
  localparam int DB = 4;
  localparam int QD = 4;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  dir_queue_if #(.N_PLAYERS(NP), .QUEUE_DEPTH(QD)) bus ();

  dir_queue_controller #(.N_PLAYERS(NP), .DEBOUNCE_CYCLES(DB), .QUEUE_DEPTH(QD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model state: sample history per key, explicit list per player.
  logic [3:0]    m_s1 [NP];
  logic [3:0]    m_s2 [NP];
  logic [3:0]    m_deb [NP];
  logic [3:0]    m_ev [NP];
  logic [DB-1:0] m_hist [NP][4];
  logic [3:0]    m_list [NP][QD];
  int            m_len [NP];
  logic [3:0]    m_dir [NP];
  logic          m_dv [NP];
  logic          m_ovf [NP];

  task automatic model_reset();
    for (int p = 0; p < NP; p++) begin
      m_s1[p] = 4'hF; m_s2[p] = 4'hF; m_deb[p] = 4'hF; m_ev[p] = 4'h0;
      for (int k = 0; k < 4; k++) m_hist[p][k] = '1;
      m_len[p] = 0; m_dir[p] = 4'h0; m_dv[p] = 1'b0; m_ovf[p] = 1'b0;
    end
  endtask

  task automatic model_step();
    logic [3:0] cand, refd, evn;
    logic       refv, legal;
    if (reset) begin
      model_reset();
      return;
    end
    for (int p = 0; p < NP; p++) begin
      if (!bus.stage) begin
        m_len[p] = 0;
        m_ovf[p] = 1'b0;
      end else begin
        cand = 4'b0000;
        for (int b = 3; b >= 0; b--) if (m_ev[p][b]) cand = 4'b0001 << b;
        refv  = (m_len[p] > 0) || m_dv[p];
        refd  = (m_len[p] > 0) ? m_list[p][m_len[p]-1] : m_dir[p];
        legal = (cand != 4'b0000) &&
                (!refv || (((cand & 4'b1100) != 4'b0000) != ((refd & 4'b1100) != 4'b0000)));
        if (bus.tick && m_len[p] > 0) begin
          m_dir[p] = m_list[p][0];
          m_dv[p]  = 1'b1;
          for (int i = 0; i < QD-1; i++) m_list[p][i] = m_list[p][i+1];
          m_len[p]--;
        end
        if (legal) begin
          if (m_len[p] < QD) begin
            m_list[p][m_len[p]] = cand;
            m_len[p]++;
          end else begin
            m_ovf[p] = 1'b1;
          end
        end
      end
      evn = 4'b0000;
      for (int k = 0; k < 4; k++) begin
        m_hist[p][k] = {m_hist[p][k][DB-2:0], m_s2[p][k]};
        if (m_hist[p][k] == {DB{~m_deb[p][k]}}) begin
          m_deb[p][k] = ~m_deb[p][k];
          evn[k] = ~m_deb[p][k] & bus.stage;
        end
      end
      m_ev[p] = evn;
      m_s2[p] = m_s1[p];
      m_s1[p] = bus.keys_n[4*p +: 4];
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    logic [7:0] ed;
    logic [5:0] eq;
    logic [1:0] ev, eo;
    for (int p = 0; p < NP; p++) begin
      ed[4*p +: 4] = m_dir[p];
      eq[3*p +: 3] = 3'(m_len[p]);
      ev[p] = m_dv[p];
      eo[p] = m_ovf[p];
    end
    check("dir",       32'(bus.dir),       32'(ed));
    check("dir_valid", 32'(bus.dir_valid), 32'(ev));
    check("q_count",   32'(bus.q_count),   32'(eq));
    check("overflow",  32'(bus.overflow),  32'(eo));
  endtask

  task automatic cycle();
    @(negedge clk);
    compare_model();
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    model_reset();
    bus.stage = 1'b0; bus.tick = 1'b0; bus.keys_n = 8'hFF;
    repeat (3) cycle();
    reset = 1'b0;
    bus.stage = 1'b1;
    cycle();
  endtask

  task automatic tap(input int idx);
    bus.keys_n[idx] = 1'b0;
    repeat (8) cycle();
    bus.keys_n[idx] = 1'b1;
    repeat (8) cycle();
  endtask

  task automatic do_tick();
    bus.tick = 1'b1;
    cycle();
    bus.tick = 1'b0;
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    reset = 1'b1;
    bus.stage = 1'b0; bus.tick = 1'b0; bus.keys_n = 8'hFF;
    repeat (2) cycle();
    check("reset_dir",  32'(bus.dir), 32'h0);
    check("reset_dv",   32'(bus.dir_valid), 32'h0);
    check("reset_qc",   32'(bus.q_count), 32'h0);
    check("reset_ovf",  32'(bus.overflow), 32'h0);
    reset = 1'b0;
    cycle();

    // First press: q_count rises exactly DB+3 edges after the key falls.
    bus.stage = 1'b1;
    bus.keys_n[0] = 1'b0;
    repeat (6) cycle();
    check("lat_before", 32'(bus.q_count[2:0]), 32'd0);
    cycle();
    check("lat_at",     32'(bus.q_count[2:0]), 32'd1);
    check("lat_model",  32'(m_len[0]), 32'd1);
    bus.keys_n[0] = 1'b1;
    repeat (8) cycle();
    do_tick();
    check("tick_dir",   32'(bus.dir[3:0]), 32'h1);
    check("tick_dv",    32'(bus.dir_valid[0]), 32'h1);
    check("tick_qc",    32'(bus.q_count[2:0]), 32'd0);

    // Reverse and repeat-axis turns are rejected.
    tap(1); tap(2); tap(3);
    check("legal_qc",   32'(bus.q_count[2:0]), 32'd1);
    check("legal_model", 32'(m_len[0]), 32'd1);
    do_tick();
    check("legal_dir",  32'(bus.dir[3:0]), 32'h4);

    // Short glitch is filtered.
    bus.keys_n[0] = 1'b0;
    repeat (3) cycle();
    bus.keys_n[0] = 1'b1;
    repeat (10) cycle();
    check("glitch_qc",  32'(bus.q_count[2:0]), 32'd0);

    // Fill to depth, overflow, then concurrent push and pop at full.
    apply_reset();
    tap(0); tap(2); tap(1); tap(3); tap(0);
    check("full_qc",    32'(bus.q_count[2:0]), 32'd4);
    check("full_ovf",   32'(bus.overflow[0]), 32'h1);
    bus.keys_n[1] = 1'b0;
    repeat (6) cycle();
    do_tick();
    check("pp_qc",      32'(bus.q_count[2:0]), 32'd4);
    check("pp_dir",     32'(bus.dir[3:0]), 32'h1);
    check("pp_ovf",     32'(bus.overflow[0]), 32'h1);
    bus.keys_n[1] = 1'b1;
    repeat (8) cycle();

    // Stage drop flushes both queues and clears overflow, directions hold.
    tap(4); tap(6);
    do_tick();
    check("pre_flush_qc", 32'(bus.q_count), 32'({3'd1, 3'd3}));
    bus.stage = 1'b0;
    cycle();
    bus.stage = 1'b1;
    check("flush_qc",   32'(bus.q_count), 32'h0);
    check("flush_ovf",  32'(bus.overflow), 32'h0);
    check("flush_dir",  32'(bus.dir), 32'h14);
    check("flush_dv",   32'(bus.dir_valid), 32'h3);

    // Simultaneous up+right on P1 keeps only up; P0 untouched.
    apply_reset();
    bus.keys_n[4] = 1'b0; bus.keys_n[7] = 1'b0;
    repeat (8) cycle();
    bus.keys_n = 8'hFF;
    repeat (8) cycle();
    check("prio_qc",    32'(bus.q_count), 32'({3'd1, 3'd0}));
    do_tick();
    check("prio_dir",   32'(bus.dir), 32'h10);
    check("prio_dv",    32'(bus.dir_valid), 32'h2);

    // Randomized traffic including stage drops and mid-run resets.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 5) == 0) begin
        int b;
        b = $urandom_range(0, 7);
        bus.keys_n[b] = ~bus.keys_n[b];
      end
      bus.tick  = ($urandom_range(0, 4) == 0);
      bus.stage = ($urandom_range(0, 79) != 0);
      if ($urandom_range(0, 699) == 0) begin
        reset = 1'b1;
        model_reset();
        cycle();
        cycle();
        reset = 1'b0;
      end
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/dir_queue_controller.md
DIR_QUEUE_CONTROLLER -- requirements
Module: dir_queue_controller

Interface
REQ-001 Parameter N_PLAYERS, default 2: number of independent direction channels, each with four keys.
REQ-002 Parameter DEBOUNCE_CYCLES, default 4: consecutive stable samples required to change a debounced key state; legal range 1..65535.
REQ-003 Parameter QUEUE_DEPTH, default 4: pending-turn entries per player; power of two, legal range 2..16.
REQ-004 clk  in  1  system clock, 50 MHz.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 stage  in  1  game-running enable; low freezes and flushes all channels.
REQ-007 tick  in  1  one-cycle game-step strobe; pops one queued turn per player.
REQ-008 keys_n  in  4*N_PLAYERS  raw active-low push buttons, per player p bits [4p+3:4p] = {right,left,down,up}.
REQ-009 dir  out  4*N_PLAYERS  registered one-hot current direction per player, same bit order as keys_n.
REQ-010 dir_valid  out  N_PLAYERS  player has a current direction.
REQ-011 q_count  out  N_PLAYERS*$clog2(QUEUE_DEPTH+1)  queue occupancy per player.
REQ-012 overflow  out  N_PLAYERS  sticky: a legal turn was dropped because the queue was full.

Function
REQ-013 Each keys_n bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-014 Each key SHALL have its own debounce counter; the debounced state SHALL flip only after the synchronized value differs from it for DEBOUNCE_CYCLES consecutive cycles; any agreeing sample SHALL clear the counter.
REQ-015 A press event SHALL be a one-cycle pulse on the debounced released-to-pressed transition; release SHALL generate no event; a held key SHALL generate exactly one event.
REQ-016 Simultaneous events within one player SHALL be resolved with priority up > down > left > right; the lower-priority events in that cycle SHALL be discarded.
REQ-017 Reference direction for a candidate event SHALL be the queue tail entry if q_count > 0, else dir if dir_valid, else none.
REQ-018 An event equal to or opposite (up/down, left/right) the reference direction SHALL be discarded; with reference none every event SHALL be legal.
REQ-019 A legal event with stage high SHALL be written to the tail; q_count SHALL increment on the next edge.
REQ-020 End-to-end latency: keys_n falling edge, held low, SHALL produce q_count increment exactly DEBOUNCE_CYCLES+3 clock edges later.
REQ-021 On tick with stage high and q_count > 0 the head entry SHALL load into dir on the next edge, dir_valid SHALL set, q_count SHALL decrement.
REQ-022 On tick with q_count = 0 dir, dir_valid and q_count SHALL be unchanged.
REQ-023 Simultaneous enqueue and pop SHALL both complete in one cycle, q_count unchanged; this SHALL hold also when q_count = QUEUE_DEPTH.
REQ-024 A legal event with q_count = QUEUE_DEPTH and no pop in that cycle SHALL be dropped and SHALL set overflow for that player.
REQ-025 Read/write pointers SHALL wrap modulo QUEUE_DEPTH with no gap or duplication.
REQ-026 While stage is low: queues SHALL be flushed (q_count = 0), no enqueue or pop SHALL occur, overflow SHALL clear, dir and dir_valid SHALL hold; debounce SHALL keep running so that no press event fires when stage rises while a key is held.
REQ-027 Players SHALL be fully independent; no event, tick effect or overflow of one player SHALL alter another.

Reset
REQ-028 While reset is high all synchronizers and debounced states SHALL be released (1), counters 0, queues empty, dir = 0, dir_valid = 0, q_count = 0, overflow = 0, regardless of clock.
REQ-029 Reset asserted mid-debounce or mid-queue SHALL discard all pending events; first event after release SHALL see reference none.

Verification (N_PLAYERS=2, DEBOUNCE_CYCLES=4, QUEUE_DEPTH=4)
REQ-030 Reset, stage=1, P0 up held low -> q_count[0]=1 exactly 7 edges later; tick -> dir[3:0]=0001, dir_valid[0]=1, q_count[0]=0.
REQ-031 dir=up; press down, then left, then right on P0 -> down and right discarded, queue = {left}; tick -> dir=0100.
REQ-032 P0 glitch low 3 cycles then high -> no event, q_count[0] stays 0.
REQ-033 Reference none, alternate legal turns up,left,down,right,up with no tick -> q_count=4, overflow[0]=1; fifth press concurrent with tick -> accepted, q_count stays 4, overflow unchanged.
REQ-034 Queue holding 3 entries, drop stage for 1 cycle -> q_count=0, overflow=0, dir held; P1 unaffected except flush.
REQ-035 Press up and right on P1 same cycle -> only up queued; P0 outputs unchanged throughout.
